// File: rtl/result_pkg.sv
// Shared definitions for the 16-bit result record stream.
// The writer, the host-side decoder and logic_control all use these definitions.
package result_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_T2   = 3'd2,
        ST_T1   = 3'd3,
        ST_T0   = 3'd4,
        ST_ADC  = 3'd5,
        ST_CSUM = 3'd6
    } state_t;

    localparam int SYNC_MSB    = 15;
    localparam int HAS_ADC_BIT = 11;
    localparam int SEQ_LSB     = 8;
    localparam int DEV_LSB     = 4;
    localparam int OP_LSB      = 0;

    localparam int WORDS_MIN = 4;
    localparam int WORDS_MID = 5;
    localparam int WORDS_MAX = 6;

    function automatic logic [15:0] make_header(
        input logic [3:0] sync,
        input logic       has_adc,
        input logic [2:0] seq,
        input logic [3:0] dev,
        input logic [3:0] op
    );
        logic [15:0] h;
        h                   = '0;
        h[SYNC_MSB -: 4]    = sync;
        h[HAS_ADC_BIT]      = has_adc;
        h[SEQ_LSB +: 3]     = seq;
        h[DEV_LSB +: 4]     = dev;
        h[OP_LSB +: 4]      = op;
        return h;
    endfunction

endpackage

// File: rtl/result_record_writer.sv
// Serialises one result record per handshake into header, 48-bit timestamp,
// optional ADC word and optional XOR checksum on the 16-bit FIFO write port.
module result_record_writer
    import result_pkg::*;
#(
    parameter logic [3:0] SYNC        = 4'hA,
    parameter bit         EN_CHECKSUM = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rec_valid,
    output logic        rec_ready,
    input  logic [3:0]  rec_dev,
    input  logic [3:0]  rec_op,
    input  logic [47:0] rec_time,
    input  logic [13:0] rec_adc,
    input  logic        rec_has_adc,
    input  logic        fifo_full,
    output logic        data_write,
    output logic [15:0] data_out,
    output logic        busy,
    output logic [15:0] rec_count
);

    state_t      state;
    state_t      state_next;
    logic        rdy_en;
    logic        accept;
    logic        last;
    logic [2:0]  seq;
    logic [15:0] csum;
    logic [3:0]  hold_dev;
    logic [3:0]  hold_op;
    logic [47:0] hold_time;
    logic [13:0] hold_adc;
    logic        hold_has_adc;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (accept)     state_next = ST_HDR;
            ST_HDR:  if (data_write) state_next = ST_T2;
            ST_T2:   if (data_write) state_next = ST_T1;
            ST_T1:   if (data_write) state_next = ST_T0;
            ST_T0:   if (data_write) state_next = hold_has_adc ? ST_ADC :
                                                  (EN_CHECKSUM ? ST_CSUM : ST_IDLE);
            ST_ADC:  if (data_write) state_next = EN_CHECKSUM ? ST_CSUM : ST_IDLE;
            ST_CSUM: if (data_write) state_next = ST_IDLE;
            default:                 state_next = ST_IDLE;
        endcase
    end

    // Write and ready are gated by rst_n so nothing moves during a reset cycle.
    always_comb begin
        busy       = (state != ST_IDLE);
        data_write = busy & ~fifo_full & rst_n;
        rec_ready  = (state == ST_IDLE) & rdy_en & rst_n;
        case (state)
            ST_HDR:  data_out = make_header(SYNC, hold_has_adc, seq, hold_dev, hold_op);
            ST_T2:   data_out = hold_time[47:32];
            ST_T1:   data_out = hold_time[31:16];
            ST_T0:   data_out = hold_time[15:0];
            ST_ADC:  data_out = {2'b00, hold_adc};
            ST_CSUM: data_out = csum;
            default: data_out = 16'h0000;
        endcase
    end

    assign accept = rec_valid & rec_ready;
    assign last   = data_write & (state_next == ST_IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdy_en    <= 1'b0;
            seq       <= 3'd0;
            rec_count <= 16'd0;
        end else begin
            rdy_en <= 1'b1;
            if (last) begin
                seq       <= seq + 3'd1;
                rec_count <= rec_count + 16'd1;
            end
        end
    end

    // Holding registers and checksum only need defined contents after an accept.
    always_ff @(posedge clk) begin
        if (accept) begin
            hold_dev     <= rec_dev;
            hold_op      <= rec_op;
            hold_time    <= rec_time;
            hold_adc     <= rec_adc;
            hold_has_adc <= rec_has_adc;
            csum         <= 16'h0000;
        end else if (data_write) begin
            csum <= csum ^ data_out;
        end
    end

endmodule

// File: tb/tb_result_record_writer.sv
// Directed table-driven bench for result_record_writer, with hand-written
// sequences for FIFO back-pressure, mid-record reset and the no-checksum build.
module tb_result_record_writer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rec_valid, rec_valid_nc;
    logic [3:0]  rec_dev, rec_op;
    logic [47:0] rec_time;
    logic [13:0] rec_adc;
    logic        rec_has_adc;
    logic        fifo_full;

    logic        rec_ready, data_write, busy;
    logic [15:0] data_out, rec_count;
    logic        rec_ready_nc, data_write_nc, busy_nc;
    logic [15:0] data_out_nc, rec_count_nc;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    result_record_writer #(.SYNC(4'hA), .EN_CHECKSUM(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .rec_valid(rec_valid), .rec_ready(rec_ready),
        .rec_dev(rec_dev), .rec_op(rec_op), .rec_time(rec_time), .rec_adc(rec_adc),
        .rec_has_adc(rec_has_adc), .fifo_full(fifo_full), .data_write(data_write),
        .data_out(data_out), .busy(busy), .rec_count(rec_count)
    );

    result_record_writer #(.SYNC(4'hA), .EN_CHECKSUM(1'b0)) dut_nc (
        .clk(clk), .rst_n(rst_n), .rec_valid(rec_valid_nc), .rec_ready(rec_ready_nc),
        .rec_dev(rec_dev), .rec_op(rec_op), .rec_time(rec_time), .rec_adc(rec_adc),
        .rec_has_adc(rec_has_adc), .fifo_full(fifo_full), .data_write(data_write_nc),
        .data_out(data_out_nc), .busy(busy_nc), .rec_count(rec_count_nc)
    );

    typedef struct {
        logic [3:0]  dev;
        logic [3:0]  op;
        logic [47:0] tm;
        logic [13:0] adc;
        logic        has;
        int          len;
        logic [15:0] w [6];
    } rec_t;

    function automatic rec_t mk(input logic [3:0] dev, input logic [3:0] op,
                                input logic [47:0] tm, input logic [13:0] adc,
                                input logic has, input int len,
                                input logic [15:0] w0, input logic [15:0] w1,
                                input logic [15:0] w2, input logic [15:0] w3,
                                input logic [15:0] w4, input logic [15:0] w5);
        rec_t r;
        r.dev = dev; r.op = op; r.tm = tm; r.adc = adc; r.has = has; r.len = len;
        r.w[0] = w0; r.w[1] = w1; r.w[2] = w2; r.w[3] = w3; r.w[4] = w4; r.w[5] = w5;
        return r;
    endfunction

    task automatic check(input string nm, input logic [47:0] act, input logic [47:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive_rec(input rec_t v);
        rec_dev = v.dev; rec_op = v.op; rec_time = v.tm;
        rec_adc = v.adc; rec_has_adc = v.has;
    endtask

    task automatic scramble;
        rec_dev = ~rec_dev; rec_op = ~rec_op; rec_time = ~rec_time;
        rec_adc = ~rec_adc; rec_has_adc = ~rec_has_adc;
    endtask

    // Offer a record, then expect its words on consecutive cycles with no back-pressure.
    task automatic run_rec(input rec_t v, input bit nc, input string tag);
        @(negedge clk);
        drive_rec(v);
        if (nc) rec_valid_nc = 1'b1; else rec_valid = 1'b1;
        #1 check({tag, " ready"}, nc ? rec_ready_nc : rec_ready, 1'b1);
        @(posedge clk);
        #1 rec_valid = 1'b0; rec_valid_nc = 1'b0;
        scramble();
        for (int i = 0; i < v.len; i++) begin
            @(negedge clk);
            check($sformatf("%s w%0d write", tag, i), nc ? data_write_nc : data_write, 1'b1);
            check($sformatf("%s w%0d data", tag, i), nc ? data_out_nc : data_out, v.w[i]);
        end
        @(negedge clk);
        check({tag, " end write"}, nc ? data_write_nc : data_write, 1'b0);
        check({tag, " end busy"}, nc ? busy_nc : busy, 1'b0);
    endtask

    rec_t vec [4];
    rec_t r;
    logic [15:0] hdr;
    logic [2:0]  sq;

    initial begin
        rst_n = 1'b0; rec_valid = 1'b0; rec_valid_nc = 1'b0; fifo_full = 1'b0;
        rec_dev = '0; rec_op = '0; rec_time = '0; rec_adc = '0; rec_has_adc = 1'b0;

        vec[0] = mk(4'h1, 4'h2, 48'h0001_0002_0003, 14'h1ABC, 1'b1, 6,
                    16'hA812, 16'h0001, 16'h0002, 16'h0003, 16'h1ABC, 16'hB2AE);
        vec[1] = mk(4'h1, 4'h2, 48'h0001_0002_0003, 14'h1ABC, 1'b0, 5,
                    16'hA112, 16'h0001, 16'h0002, 16'h0003, 16'hA112, 16'h0000);
        vec[2] = mk(4'hF, 4'h5, 48'h1234_5678_9ABC, 14'h3FFF, 1'b1, 6,
                    16'hAAF5, 16'h1234, 16'h5678, 16'h9ABC, 16'h3FFF, 16'h4BFA);
        vec[3] = mk(4'h0, 4'h0, 48'hFFFF_0000_FFFF, 14'h1234, 1'b0, 5,
                    16'hA300, 16'hFFFF, 16'h0000, 16'hFFFF, 16'hA300, 16'h0000);

        repeat (3) @(negedge clk);
        check("rst ready", rec_ready, 1'b0);
        check("rst busy", busy, 1'b0);
        check("rst write", data_write, 1'b0);
        check("rst data", data_out, 16'h0000);
        check("rst count", rec_count, 16'h0000);
        rst_n = 1'b1;
        #1 check("ready before first edge", rec_ready, 1'b0);
        @(negedge clk);
        check("ready after release", rec_ready, 1'b1);

        for (int i = 0; i < 4; i++) begin
            run_rec(vec[i], 1'b0, $sformatf("vec%0d", i));
            check($sformatf("vec%0d count", i), rec_count, 16'(i + 1));
        end

        // Back-pressure while T1 is presented.
        @(negedge clk);
        rec_dev = 4'h3; rec_op = 4'hC; rec_time = 48'h0A0B_0C0D_0E0F;
        rec_adc = 14'h0; rec_has_adc = 1'b0; rec_valid = 1'b1;
        @(posedge clk);
        #1 rec_valid = 1'b0; scramble();
        @(negedge clk); check("bp hdr", data_out, 16'hA43C); check("bp hdr wr", data_write, 1'b1);
        @(negedge clk); check("bp t2", data_out, 16'h0A0B);
        @(negedge clk);
        fifo_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 check($sformatf("bp hold%0d wr", i), data_write, 1'b0);
            check($sformatf("bp hold%0d data", i), data_out, 16'h0C0D);
            @(negedge clk);
        end
        fifo_full = 1'b0;
        #1 check("bp release wr", data_write, 1'b1);
        check("bp release data", data_out, 16'h0C0D);
        @(negedge clk); check("bp t0", data_out, 16'h0E0F); check("bp t0 wr", data_write, 1'b1);
        @(negedge clk); check("bp csum", data_out, 16'hAC35); check("bp csum wr", data_write, 1'b1);
        @(negedge clk); check("bp end wr", data_write, 1'b0);
        check("bp count", rec_count, 16'd5);

        // Reset while the ADC word is presented.
        @(negedge clk);
        drive_rec(vec[0]); rec_valid = 1'b1;
        @(posedge clk);
        #1 rec_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("mid adc data", data_out, 16'h1ABC);
        rst_n = 1'b0;
        #1 check("mid rst wr", data_write, 1'b0);
        @(negedge clk);
        check("mid rst wr2", data_write, 1'b0);
        check("mid rst busy", busy, 1'b0);
        check("mid rst count", rec_count, 16'h0000);
        check("mid rst ready", rec_ready, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        check("mid rst idle wr", data_write, 1'b0);

        // Nine records: sequence numbers wrap 7 -> 0.
        for (int i = 0; i < 9; i++) begin
            sq  = 3'(i);
            hdr = {4'hA, 1'b0, sq, 4'h5, 4'h6};
            r = mk(4'h5, 4'h6, 48'h0, 14'h0, 1'b0, 5, hdr, 16'h0, 16'h0, 16'h0, hdr, 16'h0);
            run_rec(r, 1'b0, $sformatf("seq%0d", i));
        end
        check("seq count", rec_count, 16'd9);

        // No-checksum build: five words ending in the ADC word.
        r = mk(4'h1, 4'h2, 48'h0001_0002_0003, 14'h1ABC, 1'b1, 5,
               16'hA812, 16'h0001, 16'h0002, 16'h0003, 16'h1ABC, 16'h0000);
        run_rec(r, 1'b1, "nocsum");
        check("nocsum count", rec_count_nc, 16'd1);
        check("nocsum main idle", rec_count, 16'd9);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
